// File: rtl/i2c_master_byte.sv
// rtl/i2c_master_byte.sv - single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP
// Define I2C_NACK_ABORT_EN to skip the data phase when the address is NACKed.
module i2c_master_byte #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] qcnt, qcnt_nxt;
  logic [1:0]    q, q_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    tx_sh, tx_sh_nxt;
  logic [7:0]    rx_sh, rx_sh_nxt;
  logic [7:0]    wdata_l, wdata_l_nxt;
  logic          rw_l, rw_l_nxt;
  logic [7:0]    data_rd_nxt;
  logic          busy_nxt, done_nxt, ack_err_nxt;
  logic          scl_nxt, sda_oe, sda_oe_nxt;
  logic          sda_in, tick, bit_end, sample;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Anything but a solid 0 on the bus reads as the pulled-up 1.
  always_comb begin
    case (sda)
      1'b0:    sda_in = 1'b0;
      default: sda_in = 1'b1;
    endcase
  end

  assign tick    = (qcnt == CW'(DIV - 1));
  assign sample  = tick && (q == 2'd2);
  assign bit_end = tick && (q == 2'd3);

  always_comb begin
    state_nxt   = state;
    qcnt_nxt    = qcnt;
    q_nxt       = q;
    bit_cnt_nxt = bit_cnt;
    tx_sh_nxt   = tx_sh;
    rx_sh_nxt   = rx_sh;
    wdata_l_nxt = wdata_l;
    rw_l_nxt    = rw_l;
    data_rd_nxt = data_rd;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    ack_err_nxt = ack_err;
    scl_nxt     = 1'b1;
    sda_oe_nxt  = 1'b0;

    if (state == IDLE) begin
      qcnt_nxt = '0;
      q_nxt    = 2'd0;
      if (go) begin
        state_nxt   = START;
        busy_nxt    = 1'b1;
        ack_err_nxt = 1'b0;
        tx_sh_nxt   = {addr, rw};
        rw_l_nxt    = rw;
        wdata_l_nxt = data_wr;
      end
    end else begin
      qcnt_nxt = tick ? '0 : qcnt + CW'(1);
      if (tick) q_nxt = q + 2'd1;
    end

    // Last clk of q2: SCL is mid-high and the slave's drive has settled.
    if (sample) begin
      case (state)
        ADDR_ACK, WACK: if (sda_in) ack_err_nxt = 1'b1;
        RDATA:          rx_sh_nxt = {rx_sh[6:0], sda_in};
        default: ;
      endcase
    end

    if (bit_end) begin
      case (state)
        START: begin
          state_nxt   = ADDR;
          bit_cnt_nxt = 3'd7;
        end
        ADDR, WDATA: begin
          if (bit_cnt == 3'd0) begin
            state_nxt = (state == ADDR) ? ADDR_ACK : WACK;
          end else begin
            bit_cnt_nxt = bit_cnt - 3'd1;
            tx_sh_nxt   = {tx_sh[6:0], 1'b0};
          end
        end
        ADDR_ACK: begin
          bit_cnt_nxt = 3'd7;
          tx_sh_nxt   = wdata_l;
          state_nxt   = rw_l ? RDATA : WDATA;
`ifdef I2C_NACK_ABORT_EN
          if (ack_err) state_nxt = STOP;
`endif
        end
        RDATA: begin
          if (bit_cnt == 3'd0) begin
            state_nxt   = RNACK;
            data_rd_nxt = rx_sh;
          end else begin
            bit_cnt_nxt = bit_cnt - 3'd1;
          end
        end
        WACK, RNACK: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
        default: ;
      endcase
    end

    // Pins are registered from the upcoming phase so they change cleanly on the phase edge.
    case (state_nxt)
      START: begin
        scl_nxt    = (q_nxt != 2'd3);
        sda_oe_nxt = (q_nxt != 2'd0);
      end
      ADDR, WDATA: begin
        scl_nxt    = q_nxt[1];
        sda_oe_nxt = ~tx_sh_nxt[7];
      end
      ADDR_ACK, WACK, RDATA, RNACK: scl_nxt = q_nxt[1];
      STOP: begin
        scl_nxt    = (q_nxt != 2'd0);
        sda_oe_nxt = ~q_nxt[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      q       <= 2'd0;
      bit_cnt <= 3'd0;
      tx_sh   <= 8'd0;
      rx_sh   <= 8'd0;
      wdata_l <= 8'd0;
      rw_l    <= 1'b0;
      data_rd <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      qcnt    <= qcnt_nxt;
      q       <= q_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_sh   <= tx_sh_nxt;
      rx_sh   <= rx_sh_nxt;
      wdata_l <= wdata_l_nxt;
      rw_l    <= rw_l_nxt;
      data_rd <= data_rd_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      ack_err <= ack_err_nxt;
      scl     <= scl_nxt;
      sda_oe  <= sda_oe_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// tb/tb_i2c_master_byte.sv - scoreboard bench for i2c_master_byte with a behavioural I2C slave on the bus
module tb_i2c_master_byte;

  localparam int DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'd101;

  logic       clk = 1'b0;
  logic       rst, go, rw;
  logic [6:0] addr;
  logic [7:0] data_wr, data_rd;
  logic       busy, done, ack_err, scl;
  wire        sda;
  logic       sda_v;
  logic       s_oe;

  pullup (sda);
  assign sda   = s_oe ? 1'b0 : 1'bz;
  assign sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;

  i2c_master_byte #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .go(go), .addr(addr), .rw(rw), .data_wr(data_wr),
    .data_rd(data_rd), .busy(busy), .done(done), .ack_err(ack_err),
    .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc;
    int          lat;
    logic [7:0]  rd;
    logic        ack;
    logic [7:0]  srx;
    logic [17:0] bits;
    int          nbits;
    int          starts0;
    int          stops0;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0, errors = 0, cyc = 0;
  int         starts = 0, stops = 0;
  int         rise_t[$];
  logic       rise_v[$];
  logic [7:0] slave_tx = 8'd0, slave_rx = 8'd0;
  logic [7:0] model_rd = 8'd0, model_srx = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Behavioural slave at SLV_ADDR: ACKs its address, stores written bytes, serves slave_tx on reads.
  initial begin
    logic pscl, psda, active, sel, srd;
    int sbit;
    logic [7:0] sh;
    s_oe = 1'b0; pscl = 1'b1; psda = 1'b1; active = 1'b0; sel = 1'b0; srd = 1'b0; sbit = 0; sh = 8'd0;
    forever begin
      @(scl or sda_v);
      if (pscl && scl && psda && !sda_v) begin
        active = 1'b1; sbit = 0; sel = 1'b0; s_oe = 1'b0;
      end else if (pscl && scl && !psda && sda_v) begin
        active = 1'b0; s_oe = 1'b0;
      end else if (!pscl && scl && active) begin
        if (sbit < 8 || (sbit >= 9 && sbit < 17)) sh = {sh[6:0], sda_v};
        sbit++;
        if (sbit == 8) begin sel = (sh[7:1] == SLV_ADDR); srd = sh[0]; end
        if (sbit == 17 && sel && !srd) slave_rx = sh;
      end else if (pscl && !scl && active) begin
        s_oe = 1'b0;
        if (sbit == 8 && sel) s_oe = 1'b1;
        else if (sel && srd && sbit >= 9 && sbit < 17) s_oe = ~slave_tx[16-sbit];
        else if (sel && !srd && sbit == 17) s_oe = 1'b1;
      end
      pscl = scl; psda = sda_v;
    end
  end

  // Bus observer plus scoreboard consumer, triggered by done.
  initial begin
    logic pscl, psda;
    exp_t e;
    int bad;
    logic [17:0] ob;
    pscl = 1'b1; psda = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin pscl = scl; psda = sda_v; continue; end
      if (pscl && scl && psda && !sda_v) begin starts++; rise_t.delete(); rise_v.delete(); end
      if (pscl && scl && !psda && sda_v) stops++;
      if (!pscl && scl) begin rise_t.push_back(cyc); rise_v.push_back(sda_v); end
      pscl = scl; psda = sda_v;
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at clk %0d required no done", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          chk("data_rd", int'(data_rd), int'(e.rd));
          chk("ack_err", int'(ack_err), int'(e.ack));
          chk("busy_at_done", int'(busy), 0);
          chk("slave_rx", int'(slave_rx), int'(e.srx));
          chk("start_count", starts - e.starts0, 1);
          chk("stop_count", stops - e.stops0, 1);
          chk("scl_rises", rise_t.size(), e.nbits + 1);
          ob = 18'd0; bad = 0;
          for (int i = 0; i < e.nbits && i < rise_v.size(); i++) ob[i] = rise_v[i];
          chk("wire_bits", int'(ob), int'(e.bits));
          for (int i = 1; i < e.nbits && i < rise_t.size(); i++)
            if (rise_t[i] - rise_t[i-1] != 4 * DIV) bad++;
          chk("scl_period", bad, 0);
        end
      end
    end
  end

  // Reference: the slave ACKs only SLV_ADDR; an unanswered read returns all ones.
  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
    exp_t e;
    logic match, nack, abort;
    logic [7:0] byt;
    match = (a == SLV_ADDR);
    nack  = !match;
    abort = 1'b0;
`ifdef I2C_NACK_ABORT_EN
    abort = nack;
`endif
    @(negedge clk); addr = a; rw = r; data_wr = d; go = 1'b1;
    @(negedge clk); go = 1'b0; e.acc = cyc;
    addr = ~a; rw = ~r; data_wr = ~d;
    byt = r ? (match ? slave_tx : 8'hFF) : d;
    if (r && !abort) model_rd = byt;
    if (!r && match) model_srx = d;
    e.lat = abort ? 44 * DIV : 80 * DIV;
    e.nbits = abort ? 9 : 18;
    e.rd = model_rd; e.ack = nack; e.srx = model_srx;
    e.bits = 18'd0;
    for (int i = 0; i < 7; i++) e.bits[i] = a[6-i];
    e.bits[7] = r;
    e.bits[8] = nack;
    if (!abort) begin
      for (int i = 0; i < 8; i++) e.bits[9+i] = byt[7-i];
      e.bits[17] = r ? 1'b1 : nack;
    end
    e.starts0 = starts; e.stops0 = stops;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int lim;
    lim = 0;
    while (sb.size() != 0 && lim < 100 * DIV) begin @(negedge clk); lim++; end
    chk("done_within_budget", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d, input int busy_go_at);
    issue(a, r, d);
    if (busy_go_at > 0) begin
      repeat (busy_go_at - 1) @(negedge clk);
      go = 1'b1;
      @(negedge clk); go = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    rst = 1'b1; go = 1'b0; addr = 7'd0; rw = 1'b0; data_wr = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda_v), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_data_rd", int'(data_rd), 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(SLV_ADDR, 1'b0, 8'hA5, 0);
    slave_tx = 8'h3C;
    run_txn(SLV_ADDR, 1'b1, 8'h55, 0);
    run_txn(7'd100, 1'b0, 8'h77, 0);
    run_txn(SLV_ADDR, 1'b0, 8'hC3, 50);

    // Reset during the fourth data bit while SCL is low and SDA is driven low.
    @(negedge clk); addr = SLV_ADDR; rw = 1'b0; data_wr = 8'hE7; go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (53 * DIV) @(negedge clk);
    chk("pre_reset_scl", int'(scl), 0);
    chk("pre_reset_sda", int'(sda_v), 0);
    rst = 1'b1;
    #1;
    chk("midrst_scl", int'(scl), 1);
    chk("midrst_sda", int'(sda_v), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_data_rd", int'(data_rd), 0);
    @(negedge clk); rst = 1'b0;
    model_rd = 8'd0;
    @(negedge clk);
    run_txn(SLV_ADDR, 1'b0, 8'h5A, 0);

    for (int n = 0; n < 12; n++) begin
      a = ($urandom_range(0, 1) == 1) ? SLV_ADDR : 7'($urandom_range(0, 127));
      slave_tx = 8'($urandom);
      run_txn(a, 1'($urandom), 8'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
